// File: rtl/debounce_pkg.sv
// Shared types and elaboration helpers for the push-button debouncer.
package debounce_pkg;

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_CLOSED = 1'b1
  } deb_state_t;

  function automatic int ms_to_cycles(int clk_freq, int ms);
    return clk_freq / 1000 * ms;
  endfunction

  function automatic int cnt_width(int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/button_debouncer_n_if.sv
// Front-panel button bus: raw buttons in, conditioned level and pulses out.
interface button_debouncer_n_if #(
  parameter int NUM_CH = 4
) ();

  // "release" is a reserved word, so the falling-edge pulse is named released
  logic [NUM_CH-1:0] button;
  logic [NUM_CH-1:0] level;
  logic [NUM_CH-1:0] press;
  logic [NUM_CH-1:0] released;
  logic [NUM_CH-1:0] long_press;

  modport master (
    output button,
    input  level,
    input  press,
    input  released,
    input  long_press
  );

  modport slave (
    input  button,
    output level,
    output press,
    output released,
    output long_press
  );

endinterface

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, symmetric debounce and long-press timer.
//   state     | meaning
//   ST_OPEN   | debounced level is 0 (button up)
//   ST_CLOSED | debounced level is 1 (button down)
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CYC  = 8,
  parameter int HOLD_CYC    = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic level,
  output logic press,
  output logic released,
  output logic long_press
);

  localparam int CW = cnt_width(STABLE_CYC);
  localparam logic [CW-1:0] CNT_TC = CW'(STABLE_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  deb_state_t             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   press_q, press_d;
  logic                   rel_q, rel_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], button};
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_OPEN;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  // Any sample equal to the current level throws away the accumulated count.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (s != level) begin
      if (cnt_q == CNT_TC) begin
        state_d = s ? ST_CLOSED : ST_OPEN;
        press_d = s;
        rel_d   = ~s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign level    = (state_q == ST_CLOSED);
  assign press    = press_q;
  assign released = rel_q;

  generate
    if (HOLD_CYC > 0) begin : g_hold
      localparam int HW = cnt_width(HOLD_CYC);
      localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYC);
      localparam logic [HW-1:0] HOLD_PRE = HW'(HOLD_CYC - 1);

      logic [HW-1:0] hcnt_q;
      logic          long_q;

      // hcnt is 0 in the press cycle, so it reaches HOLD_CYC that many cycles later
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hcnt_q <= '0;
          long_q <= 1'b0;
        end else begin
          long_q <= level && (hcnt_q == HOLD_PRE);
          if (!level)                  hcnt_q <= '0;
          else if (hcnt_q != HOLD_MAX) hcnt_q <= hcnt_q + 1'b1;
        end
      end

      assign long_press = long_q;
    end else begin : g_no_hold
      assign long_press = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/button_debouncer_n.sv
// Multi-channel push-button conditioner: one independent debounce_channel per button.
module button_debouncer_n
  import debounce_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CLK_FREQ    = 50_000_000,
  parameter int STABLE_MS   = 10,
  parameter int HOLD_MS     = 1000,
  parameter int SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                rst,
  button_debouncer_n_if.slave bus
);

  localparam int STABLE_CYC = ms_to_cycles(CLK_FREQ, STABLE_MS);
  localparam int HOLD_CYC   = ms_to_cycles(CLK_FREQ, HOLD_MS);

  generate
    if (NUM_CH < 1) begin : g_chk_ch
      $error("button_debouncer_n: NUM_CH must be at least 1");
    end
    if (STABLE_CYC < 1) begin : g_chk_stable
      $error("button_debouncer_n: STABLE_CYC must be at least 1");
    end
    if (HOLD_CYC < 0) begin : g_chk_hold
      $error("button_debouncer_n: HOLD_CYC must not be negative");
    end
    if (SYNC_STAGES < 2) begin : g_chk_sync
      $error("button_debouncer_n: SYNC_STAGES must be at least 2");
    end
  endgenerate

  logic [NUM_CH-1:0] level_v, press_v, rel_v, long_v;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      debounce_channel #(
        .STABLE_CYC  (STABLE_CYC),
        .HOLD_CYC    (HOLD_CYC),
        .SYNC_STAGES (SYNC_STAGES)
      ) u_ch (
        .clk        (clk),
        .rst        (rst),
        .button     (bus.button[i]),
        .level      (level_v[i]),
        .press      (press_v[i]),
        .released   (rel_v[i]),
        .long_press (long_v[i])
      );
    end
  endgenerate

  assign bus.level      = level_v;
  assign bus.press      = press_v;
  assign bus.released   = rel_v;
  assign bus.long_press = long_v;

endmodule

// File: tb/tb_button_debouncer_n.sv
// Scoreboard bench: stimulus queues expected pulses, a negedge monitor pops and compares.
module tb_button_debouncer_n;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;
  localparam int LAT     = 10;
  localparam int HOLD    = 20;

  typedef struct {
    int ch;
    int kind;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  ev_t  got;
  logic mv;

  button_debouncer_n_if #(.NUM_CH(4)) bus ();

  button_debouncer_n #(
    .NUM_CH      (4),
    .CLK_FREQ    (4000),
    .STABLE_MS   (2),
    .HOLD_MS     (5),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int ch, input int kind, input int at);
    ev_t e;
    e.ch = ch; e.kind = kind; e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic check_eq(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check_eq({name, " level"},      int'(bus.level),      0);
    check_eq({name, " press"},      int'(bus.press),      0);
    check_eq({name, " released"},   int'(bus.released),   0);
    check_eq({name, " long_press"}, int'(bus.long_press), 0);
  endtask

  // Pulses are visited in channel order, then press/released/long_press order.
  always @(negedge clk) begin
    for (int ch = 0; ch < 4; ch++) begin
      for (int k = 0; k < 3; k++) begin
        mv = (k == K_PRESS) ? bus.press[ch] :
             (k == K_REL)   ? bus.released[ch] : bus.long_press[ch];
        if (mv) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected pulse: ch%0d kind%0d at cyc %0d, required none", ch, k, cyc);
          end else begin
            got = exp_q.pop_front();
            if (got.ch != ch || got.kind != k || got.cyc != cyc) begin
              errors++;
              $display("FAIL pulse: got ch%0d kind%0d cyc %0d, required ch%0d kind%0d cyc %0d",
                       ch, k, cyc, got.ch, got.kind, got.cyc);
            end
          end
          check_eq($sformatf("level at pulse ch%0d kind%0d", ch, k),
                   int'(bus.level[ch]), (k == K_REL) ? 0 : 1);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.button = 4'hF;
    tick(3);
    check_outputs_zero("in reset");

    // release reset with every button already down
    rst = 1'b0;
    for (int ch = 0; ch < 4; ch++) expect_ev(ch, K_PRESS, cyc + LAT);
    tick(12);
    bus.button = 4'h0;
    for (int ch = 0; ch < 4; ch++) expect_ev(ch, K_REL, cyc + LAT);
    tick(15);

    // clean press/release on ch0
    bus.button[0] = 1'b1;
    expect_ev(0, K_PRESS, cyc + LAT);
    tick(15);
    bus.button[0] = 1'b0;
    expect_ev(0, K_REL, cyc + LAT);
    tick(15);

    // bounce on ch1: pulses of 1..7 cycles never qualify
    for (int w = 1; w <= 7; w++) begin
      bus.button[1] = 1'b1;
      tick(w);
      bus.button[1] = 1'b0;
      tick(w);
    end
    bus.button[1] = 1'b1;
    expect_ev(1, K_PRESS, cyc + LAT);
    tick(15);
    bus.button[1] = 1'b0;
    expect_ev(1, K_REL, cyc + LAT);
    tick(15);

    // long press on ch2
    bus.button[2] = 1'b1;
    expect_ev(2, K_PRESS, cyc + LAT);
    expect_ev(2, K_LONG, cyc + LAT + HOLD);
    tick(40);
    bus.button[2] = 1'b0;
    expect_ev(2, K_REL, cyc + LAT);
    tick(15);

    // concurrent: ch1 held, then ch0/ch3 pressed while ch1 released
    bus.button[1] = 1'b1;
    expect_ev(1, K_PRESS, cyc + LAT);
    tick(15);
    bus.button = 4'b1001;
    expect_ev(0, K_PRESS, cyc + LAT);
    expect_ev(1, K_REL,   cyc + LAT);
    expect_ev(3, K_PRESS, cyc + LAT);
    tick(15);
    bus.button = 4'b0000;
    expect_ev(0, K_REL, cyc + LAT);
    expect_ev(3, K_REL, cyc + LAT);
    tick(15);

    // reset on ch2 with cnt==5 (release in progress) and hcnt==12
    bus.button[2] = 1'b1;
    expect_ev(2, K_PRESS, cyc + LAT);
    tick(15);
    bus.button[2] = 1'b0;
    tick(7);
    check_eq("ch2 level before mid reset", int'(bus.level[2]), 1);
    rst = 1'b1;
    #1;
    check_outputs_zero("mid reset");
    tick(3);
    rst = 1'b0;
    tick(30);
    check_eq("level after mid reset", int'(bus.level), 0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      while (exp_q.size() != 0) begin
        got = exp_q.pop_front();
        $display("FAIL missing pulse: ch%0d kind%0d required at cyc %0d, never seen",
                 got.ch, got.kind, got.cyc);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_debouncer_n.md
# button_debouncer_n

Parametrised multi-channel push-button conditioner for the guessing-game front panel. Each of `NUM_CH` raw, asynchronous button inputs is synchronised and debounced symmetrically: both press and release must be stable for a programmable time. Each channel then produces a clean level, one-cycle press and release pulses, and an optional one-shot long-press pulse. It sits between the board pins and the game FSM.

## Interface
- `NUM_CH`, 4: number of independent button channels (≥1).
- `CLK_FREQ`, 50_000_000: clock frequency in Hz.
- `STABLE_MS`, 10: debounce time in ms. `STABLE_CYC = CLK_FREQ/1000*STABLE_MS` (integer math, evaluated in that order). Must be ≥1; elaboration fails otherwise.
- `HOLD_MS`, 1000: long-press time in ms. `HOLD_CYC = CLK_FREQ/1000*HOLD_MS`. A value of 0 disables long-press detection.
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2).
- `clk`, in, 1: system clock, all logic on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `button`, in, `NUM_CH`: raw active-high buttons, asynchronous to `clk`.
- `level`, out, `NUM_CH`: debounced button state.
- `press`, out, `NUM_CH`: one-cycle pulse when `level` rises.
- `release`, out, `NUM_CH`: one-cycle pulse when `level` falls.
- `long_press`, out, `NUM_CH`: one-cycle pulse when `level` has been 1 for `HOLD_CYC` cycles.

## Operation
- Channels are fully independent. There is no cross-channel state or priority.
- **Reset:** all synchroniser flops, `level`, `press`, `release`, `long_press`, and all counters clear to 0.
- **Synchroniser:** a `SYNC_STAGES`-deep flop chain. Its last stage is `s`.
- **Debounce counter** `cnt`, width `$clog2(STABLE_CYC+1)`:
  - If `s == level`: `cnt <= 0`.
  - Else, if `cnt == STABLE_CYC-1`: `level <= s`, `cnt <= 0`, and pulse `press` (for `s=1`) or `release` (for `s=0`).
  - Else: `cnt <= cnt+1`.
- A bounce of `s` back to `level` before the threshold restarts the count from 0. There is no partial credit.
- **Hold counter** `hcnt`, width `$clog2(HOLD_CYC+1)`, used only when `HOLD_MS>0`:
  - Cleared whenever `level==0` or in the cycle `press` fires.
  - Otherwise increments while `level==1`, saturating at `HOLD_CYC`.
  - `long_press` pulses exactly once, in the cycle `hcnt` transitions `HOLD_CYC-1 → HOLD_CYC`.
- Release after a long press still gives a normal `release` pulse.
- When `HOLD_MS==0`, `long_press` is constant 0 and `hcnt` is not instantiated.
- `press`, `release` and `long_press` are registered. They are never asserted for more than one consecutive cycle per channel.
- `press` and `release` of one channel are mutually exclusive in any cycle.

## Timing
- Input to `s`: `SYNC_STAGES` rising edges.
- `s` change to `level` change: exactly `STABLE_CYC` rising edges, provided `s` stays constant. The pulse is coincident with the `level` change.
- Total latency from a clean input edge: `SYNC_STAGES + STABLE_CYC` cycles, ±1 cycle from asynchronous sampling.
- Rising `level` to `long_press`: `HOLD_CYC` cycles.
- Maximum toggle rate: a new `level` edge needs at least `STABLE_CYC` cycles after the previous one.
- Reset asserted mid-count or mid-hold: everything clears immediately. After release, a held button needs a full `SYNC_STAGES + STABLE_CYC` cycles to produce `press`.

## Structure
- `debounce_pkg` holds:
  - `function automatic int ms_to_cycles(int clk_freq, int ms)`
  - `function automatic int cnt_width(int max)`, a `$clog2(max+1)` wrapper with a minimum of 1.
- Sub-module `debounce_channel` holds the synchroniser, debounce counter, and hold counter for one channel.
- The top level is a `generate for` over `NUM_CH` plus parameter checks.

## Test plan
All scenarios use `CLK_FREQ=4000`, `STABLE_MS=2` (8 cycles), `HOLD_MS=5` (20 cycles), `SYNC_STAGES=2`, `NUM_CH=4`.

- **Reset:** assert `rst` with all buttons at 1. All outputs are 0. After release, ch0 `press` fires 10 cycles later.
- **Clean press/release on ch0:** `level` rises 10 cycles after the input edge, with `press` high exactly 1 cycle. Release gives the same with `release`.
- **Bounce on ch1:** pulses of 1–7 cycles with equal gaps produce no `level` change. A following steady high of 8+ cycles gives a single `press`.
- **Long press on ch2:** hold 40 cycles. `long_press` fires exactly once, 20 cycles after `press`. Release gives `release`.
- **Concurrent channels:** ch0 and ch3 are pressed on the same cycle and ch1 is released. Pulses appear on the same cycle on each channel, with no interaction.
- **Reset mid-operation:** assert `rst` while ch2 `cnt==5` and `hcnt==12`. All outputs clear. There is no spurious pulse after deassertion with the input held low.
